// File: rtl/jtag_tap_rsp_if.sv
// JTAG link plus debug-bridge side-band bundle for the TAP responder.
//   master: JTAG initiator / bridge side (drives trstn, tms, tdi, dr_capture_i)
//   slave : TAP responder (drives tdo, tdo_en, tap_state, ir_o, dr_data_o,
//           dr_len_o, dr_valid_o)
interface jtag_tap_rsp_if #(
  parameter int unsigned IR_W = 4,
  parameter int unsigned DR_W = 64
);
  localparam int unsigned LEN_W = $clog2(DR_W) + 1;

  logic             trstn;
  logic             tms;
  logic             tdi;
  logic             tdo;
  logic             tdo_en;
  logic [3:0]       tap_state;
  logic [IR_W-1:0]  ir_o;
  logic [DR_W-1:0]  dr_capture_i;
  logic [DR_W-1:0]  dr_data_o;
  logic [LEN_W-1:0] dr_len_o;
  logic             dr_valid_o;

  modport master (
    output trstn, tms, tdi, dr_capture_i,
    input  tdo, tdo_en, tap_state, ir_o, dr_data_o, dr_len_o, dr_valid_o
  );

  modport slave (
    input  trstn, tms, tdi, dr_capture_i,
    output tdo, tdo_en, tap_state, ir_o, dr_data_o, dr_len_o, dr_valid_o
  );
endinterface

// File: rtl/jtag_tap_rsp.sv
// JTAG TAP responder: IEEE 1149.1 16-state controller, IR and three data
// registers (IDCODE, BYPASS, USER). USER hands shifted words and bit counts
// to the debug bridge and captures a bridge word for shift-out.
//   jtag_clk_i : TCK, all state updates on posedge
//   rst        : synchronous active-high reset, highest priority
//   jtag       : slave side of jtag_tap_rsp_if (TMS/TDI/TDO/TRSTn link,
//                debug tap_state/ir_o, USER capture/data/len/valid)
module jtag_tap_rsp #(
  parameter int unsigned IR_W       = 4,
  parameter int unsigned DR_W       = 64,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_1DB3,
  parameter logic [IR_W-1:0] INS_IDCODE = 4'b0010,
  parameter logic [IR_W-1:0] INS_USER   = 4'b0100,
  parameter logic [IR_W-1:0] INS_BYPASS = 4'b1111
) (
  input  logic          jtag_clk_i,
  input  logic          rst,
  jtag_tap_rsp_if.slave jtag
);

  localparam int unsigned LEN_W = $clog2(DR_W) + 1;
  localparam int unsigned ID_W  = 32;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t       state_q;
  tap_state_t       state_nxt;
  logic [IR_W-1:0]  ir_sr;
  logic [IR_W-1:0]  ir_q;
  logic [ID_W-1:0]  id_sr;
  logic             bp_sr;
  logic [DR_W-1:0]  user_sr;
  logic [LEN_W-1:0] cnt_q;
  logic [DR_W-1:0]  data_q;
  logic [LEN_W-1:0] len_q;
  logic             valid_q;
  logic             tdo_c;
  logic             sel_id;
  logic             sel_user;
  logic             sel_bypass;

  // Standard 1149.1 next-state function.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:     n = m ? TLR    : RTI;
      RTI:     n = m ? SEL_DR : RTI;
      SEL_DR:  n = m ? SEL_IR : CAP_DR;
      CAP_DR:  n = m ? EX1_DR : SH_DR;
      SH_DR:   n = m ? EX1_DR : SH_DR;
      EX1_DR:  n = m ? UPD_DR : PA_DR;
      PA_DR:   n = m ? EX2_DR : PA_DR;
      EX2_DR:  n = m ? UPD_DR : SH_DR;
      UPD_DR:  n = m ? SEL_DR : RTI;
      SEL_IR:  n = m ? TLR    : CAP_IR;
      CAP_IR:  n = m ? EX1_IR : SH_IR;
      SH_IR:   n = m ? EX1_IR : SH_IR;
      EX1_IR:  n = m ? UPD_IR : PA_IR;
      PA_IR:   n = m ? EX2_IR : PA_IR;
      EX2_IR:  n = m ? UPD_IR : SH_IR;
      UPD_IR:  n = m ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  assign state_nxt = tap_next(state_q, jtag.tms);

  // Data register select; undefined opcodes fall through to BYPASS.
  assign sel_id     = (ir_q == INS_IDCODE);
  assign sel_user   = (ir_q == INS_USER);
  assign sel_bypass = (ir_q == INS_BYPASS) || !(sel_id || sel_user);

  // TAP controller and all register updates.
  always_ff @(posedge jtag_clk_i) begin
    if (rst) begin
      state_q <= TLR;
      ir_q    <= INS_IDCODE;
      ir_sr   <= INS_IDCODE;
      id_sr   <= '0;
      bp_sr   <= 1'b0;
      user_sr <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
    end else if (!jtag.trstn) begin
      // TAP reset keeps the last word handed to the bridge.
      state_q <= TLR;
      ir_q    <= INS_IDCODE;
      ir_sr   <= INS_IDCODE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      valid_q <= 1'b0;
      case (state_q)
        CAP_IR: ir_sr <= IR_W'(2'b01);
        SH_IR:  ir_sr <= {jtag.tdi, ir_sr[IR_W-1:1]};
        UPD_IR: ir_q  <= ir_sr;
        CAP_DR: begin
          if (sel_id) begin
            id_sr <= IDCODE_VAL;
          end else if (sel_user) begin
            user_sr <= jtag.dr_capture_i;
            cnt_q   <= '0;
          end else begin
            bp_sr <= 1'b0;
          end
        end
        SH_DR: begin
          if (sel_id) begin
            id_sr <= {jtag.tdi, id_sr[ID_W-1:1]};
          end else if (sel_user) begin
            user_sr <= {jtag.tdi, user_sr[DR_W-1:1]};
            if (cnt_q != LEN_W'(DR_W)) cnt_q <= cnt_q + LEN_W'(1);
          end else begin
            bp_sr <= jtag.tdi;
          end
        end
        UPD_DR: begin
          if (sel_user) begin
            data_q  <= user_sr;
            len_q   <= cnt_q;
            valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
      // Any entry into TLR (including the 5x TMS=1 escape) restores IDCODE.
      if (state_nxt == TLR) begin
        ir_q  <= INS_IDCODE;
        ir_sr <= INS_IDCODE;
      end
    end
  end

  // TDO mirrors bit 0 of the register that the next posedge will shift.
  always_comb begin
    tdo_c = 1'b0;
    if (state_q == SH_IR) begin
      tdo_c = ir_sr[0];
    end else if (state_q == SH_DR) begin
      if (sel_id)          tdo_c = id_sr[0];
      else if (sel_user)   tdo_c = user_sr[0];
      else if (sel_bypass) tdo_c = bp_sr;
    end
  end

  assign jtag.tdo        = tdo_c;
  assign jtag.tdo_en     = (state_q == SH_IR) || (state_q == SH_DR);
  assign jtag.tap_state  = state_q;
  assign jtag.ir_o       = ir_q;
  assign jtag.dr_data_o  = data_q;
  assign jtag.dr_len_o   = len_q;
  assign jtag.dr_valid_o = valid_q;

endmodule
